mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8: the maximum number of cycles one requester keeps the mux while another requester waits (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: request lines; req[i] high means requester i wants the shared mux.
REQ-005 The block SHALL have port d, input, 4 bits: data; d[i] is requester i's data bit.
REQ-006 The block SHALL have port grant, output, 4 bits: registered one-hot grant, or all zero when idle.
REQ-007 The block SHALL have port sel, output, 2 bits: registered mux select; it equals the index of the granted requester.
REQ-008 The block SHALL have port busy, output, 1 bit: registered; high whenever grant is nonzero.
REQ-009 The block SHALL have port y, output, 1 bit: combinational; d[sel] when busy, else 0.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and OWN (grant[sel] high).
REQ-011 In IDLE with req nonzero, the block SHALL grant at the next edge the first requesting index found when searching upward from ptr with wrap 3->0, then enter OWN; the latency from req to grant is 1 cycle.
REQ-012 In IDLE with req zero, the block SHALL remain in IDLE with grant, sel and busy unchanged at 0/00/0.
REQ-013 ptr SHALL be a 2-bit round-robin pointer set to (granted index + 1) mod 4 on every new grant.
REQ-014 In OWN, hold_cnt SHALL increment each cycle from 0 on grant and saturate at MAX_HOLD-1.
REQ-015 In OWN, if req[sel] is low at an edge (release), the block SHALL re-arbitrate at that edge from ptr among the other requests, with no idle bubble. If none are requesting, it SHALL go to IDLE and clear grant and busy; sel SHALL hold its last value.
REQ-016 In OWN, if req[sel] is still high, hold_cnt == MAX_HOLD-1 and another req bit is high, the block SHALL force a rotation at that edge to the next requester from ptr.
REQ-017 In OWN with hold_cnt saturated and no other requester, the grant SHALL persist indefinitely.
REQ-018 Any new grant SHALL reset hold_cnt to 0.
REQ-019 grant SHALL never have more than one bit set, and grant[sel] SHALL equal busy in every cycle.
REQ-020 A requester that drops and reasserts req in the same cycle as its release SHALL NOT be considered in that arbitration; it has lowest priority after ptr advances.
REQ-021 With all four requesting continuously, grants SHALL rotate 0,1,2,3,0,... and each grant SHALL last exactly MAX_HOLD cycles.

Reset
REQ-022 When rst is high at an edge, the block SHALL set state=IDLE, grant=0000, sel=00, busy=0, ptr=00 and hold_cnt=0, so y=0.
REQ-023 Reset SHALL take priority over all arbitration, including reset asserted mid-OWN; req is ignored in the reset cycle.
REQ-024 After reset deasserts, the first grant SHALL favour requester 0 when several requesters are asserted.

Structure
REQ-025 State encodings (IDLE=0, OWN=1) and the default MAX_HOLD SHALL live in shared package mux_arb_pkg.
REQ-026 The data path SHALL instantiate the existing mux4to1 as its single sub-module, with sel and d[3:0] connected, and gate its output with busy.
REQ-027 The next-owner search from ptr SHALL be one combinational function, shared by IDLE, release and timeout.

Verification
REQ-028 Reset, then req=0001 and d=0001 -> one cycle later grant=0001, sel=00, busy=1, y=1.
REQ-029 req=1111 held for 40 cycles with MAX_HOLD=8 -> sel sequence 00,01,10,11,00, each held exactly 8 cycles.
REQ-030 Owner 2 holds alone for 20 cycles -> grant stays 0100 and hold_cnt saturates at 7. Then req[0] rises -> at the next edge grant=0001.
REQ-031 Owner 1 drops req while req=1001 -> at the next edge grant=1000 (ptr search from 2), with no idle cycle.
REQ-032 Owner 3 drops req with no other requests -> grant=0000, busy=0, y=0, sel stays 11. Then req=0011 -> grant=0001.
REQ-033 rst pulsed while grant=0100 and req=1111 -> after the edge all outputs are zero. Next grant=0001.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
//   arb_state_e  : FSM encoding (IDLE=0, OWN=1)
//   MAX_HOLD_DEF : default hold limit while others wait
//   pick_t       : result of the round-robin next-owner search
//   rr_pick()    : first set bit of req searching upward from ptr, wrap 3->0
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int MAX_HOLD_DEF = 8;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Scan from the farthest offset down to ptr so the closest hit is written
  // last and wins. 2-bit addition gives the 3->0 wrap for free.
  function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    pick_t      p;
    logic [1:0] i;
    p = '0;
    for (int k = 3; k >= 0; k--) begin
      i = ptr + 2'(k);
      if (req[i]) begin
        p.found = 1'b1;
        p.idx   = i;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Plain 4:1 mux of single-bit data.
//   sel : 2-bit select
//   d   : 4 data bits
//   y   : d[sel]
module mux4to1 (
  input  logic [1:0] sel,
  input  logic [3:0] d,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   req   : request lines, req[i] = requester i wants the mux
//   d     : data bits, d[i] belongs to requester i
//   grant : registered one-hot grant, 0 when idle
//   sel   : registered mux select (index of owner; holds last value when idle)
//   busy  : registered, high whenever grant is nonzero
//   y     : d[sel] gated by busy
// An owner keeps the mux until it drops req or, while someone else waits,
// until it has held MAX_HOLD cycles.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y
);

  localparam logic [7:0] HMAX = 8'(MAX_HOLD - 1);

  arb_state_e state, state_n;
  logic [3:0] grant_n;
  logic [1:0] sel_n, ptr, ptr_n;
  logic       busy_n, take;
  logic [7:0] hold_cnt, hold_n;
  logic [3:0] cand;
  pick_t      pick;
  logic       mux_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      sel      <= sel_n;
      busy     <= busy_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  // The current owner is never a candidate: on release its req is low anyway,
  // and on timeout the rotation must go to somebody else.
  always_comb begin
    cand    = (state == OWN) ? (req & ~grant) : req;
    pick    = rr_pick(cand, ptr);
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    busy_n  = busy;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    take    = 1'b0;
    case (state)
      IDLE: take = pick.found;
      OWN: begin
        if (!req[sel]) begin
          if (pick.found) begin
            take = 1'b1;
          end else begin
            // Nobody waiting: drop to idle, sel keeps pointing at the last owner.
            state_n = IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
            hold_n  = '0;
          end
        end else if (hold_cnt == HMAX) begin
          take = pick.found;  // saturated: rotate only if someone else waits
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
    if (take) begin
      state_n = OWN;
      grant_n = 4'b0001 << pick.idx;
      sel_n   = pick.idx;
      busy_n  = 1'b1;
      ptr_n   = pick.idx + 2'd1;
      hold_n  = '0;
    end
  end

  mux4to1 u_mux (
    .sel (sel),
    .d   (d),
    .y   (mux_y)
  );

  assign y = busy & mux_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] d   = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       y;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: owner index (-1 = nobody), pointer, cycles held.
  int         m_own  = -1;
  int         m_ptr  = 0;
  int         m_sel  = 0;
  int         m_held = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .d     (d),
    .grant (grant),
    .sel   (sel),
    .busy  (busy),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got %b want %b", nm, cyc, act, exp);
    end
  endtask

  function automatic int rr_first(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic new_owner(input int c);
    m_own  = c;
    m_sel  = c;
    m_ptr  = (c + 1) % 4;
    m_held = 0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] rq);
    logic [3:0] others;
    int         c;
    if (r) begin
      m_own = -1; m_sel = 0; m_ptr = 0; m_held = 0;
    end else if (m_own < 0) begin
      c = rr_first(rq, m_ptr);
      if (c >= 0) new_owner(c);
    end else begin
      others = rq;
      others[m_own] = 1'b0;
      if (!rq[m_own]) begin
        c = rr_first(others, m_ptr);
        if (c >= 0) new_owner(c);
        else m_own = -1;
      end else if (m_held == MH - 1 && others != 4'b0) begin
        new_owner(rr_first(others, m_ptr));
      end else if (m_held < MH - 1) begin
        m_held++;
      end
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare all outputs 1 time unit later.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dd);
    logic [3:0] eg;
    logic       eb, ey;
    @(negedge clk);
    rst = r; req = rq; d = dd;
    @(posedge clk);
    cyc++;
    model_edge(r, rq);
    #1;
    eg = (m_own < 0) ? 4'b0 : (4'b0001 << m_own);
    eb = (m_own >= 0);
    ey = eb & dd[m_sel];
    chk("model_grant", grant, eg);
    chk("model_sel", {2'b0, sel}, 4'(m_sel));
    chk("model_busy", {3'b0, busy}, {3'b0, eb});
    chk("model_y", {3'b0, y}, {3'b0, ey});
  endtask

  initial begin
    logic [3:0] rq;

    // Reset state
    step(1'b1, 4'b1111, 4'b1111);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy_y", {2'b0, busy, y}, 4'b0000);

    // Single requester, one-cycle latency
    step(1'b0, 4'b0001, 4'b0001);
    chk("single_grant", grant, 4'b0001);
    chk("single_sel", {2'b0, sel}, 4'b0000);
    chk("single_busy_y", {2'b0, busy, y}, 4'b0011);

    // All four requesting: rotation every MH cycles
    step(1'b1, 4'b0000, 4'b0000);
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 4'b1111, 4'($urandom_range(0, 15)));
      if (k == 1 || k == 8 || k == 9 || k == 17 || k == 25 || k == 32 || k == 33)
        chk($sformatf("rot_sel_k%0d", k), {2'b0, sel}, 4'(((k - 1) / 8) % 4));
    end

    // Lone owner 2 saturates, then req[0] forces a rotation at once
    step(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 20; k++) step(1'b0, 4'b0100, 4'b0100);
    chk("sat_grant", grant, 4'b0100);
    step(1'b0, 4'b0101, 4'b0000);
    chk("sat_rotate", grant, 4'b0001);

    // Owner 1 releases with req=1001: search from 2 lands on 3, no bubble
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0010, 4'b0000);
    step(1'b0, 4'b1001, 4'b1000);
    chk("release_grant", grant, 4'b1000);
    chk("release_busy_y", {2'b0, busy, y}, 4'b0011);

    // Owner 3 releases alone: idle, sel holds 11, then 0011 -> 0
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b1000, 4'b1111);
    step(1'b0, 4'b0000, 4'b1111);
    chk("idle_grant", grant, 4'b0000);
    chk("idle_busy_y", {2'b0, busy, y}, 4'b0000);
    chk("idle_sel", {2'b0, sel}, 4'b0011);
    step(1'b0, 4'b0011, 4'b0000);
    chk("idle_regrant", grant, 4'b0001);

    // Reset mid-OWN
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b0100);
    step(1'b0, 4'b1111, 4'b0100);
    chk("midown_grant", grant, 4'b0100);
    step(1'b1, 4'b1111, 4'b1111);
    chk("midown_rst_grant", grant, 4'b0000);
    chk("midown_rst_sel", {2'b0, sel}, 4'b0000);
    chk("midown_rst_busy_y", {2'b0, busy, y}, 4'b0000);
    step(1'b0, 4'b1111, 4'b1111);
    chk("midown_regrant", grant, 4'b0001);

    // Random traffic with sticky requests and occasional reset
    rq = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      step($urandom_range(0, 199) == 0, rq, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
